uart_rx: RTL and testbench

//   UART serial receiver, 8N1 framing (1 start, 8 data LSB-first, 1 stop).

---
 rtl/uart_rx_if.sv | 47 ++++
 rtl/uart_rx.sv | 157 +++++++++++++++
 tb/tb_uart_rx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if - signal bundle between the board RX pin and the byte consumer.
//
// Signals:
//   i_RX_Serial     serial line into the receiver, idle high
//   o_RX_DV         one-cycle strobe, o_RX_Byte holds a freshly received byte
//   o_RX_Byte       last received byte
//   o_RX_Frame_Err  one-cycle strobe on a bad stop bit (UART_RX_FRAMING_ERR_EN only)
//
// Modports:
//   slave   the receiver (uart_rx): consumes the line, produces byte/strobes
//   master  the environment: drives the line, observes byte/strobes
interface uart_rx_if;

  logic       i_RX_Serial;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
`ifdef UART_RX_FRAMING_ERR_EN
  logic       o_RX_Frame_Err;

  modport slave (
    input  i_RX_Serial,
    output o_RX_DV,
    output o_RX_Byte,
    output o_RX_Frame_Err
  );

  modport master (
    output i_RX_Serial,
    input  o_RX_DV,
    input  o_RX_Byte,
    input  o_RX_Frame_Err
  );
`else
  modport slave (
    input  i_RX_Serial,
    output o_RX_DV,
    output o_RX_Byte
  );

  modport master (
    output i_RX_Serial,
    input  o_RX_DV,
    input  o_RX_Byte
  );
`endif

endinterface

// File: rtl/uart_rx.sv
// uart_rx - UART receiver, 8N1 framing (1 start, 8 data LSB first, 1 stop).
//
// The RX line is oversampled by the system clock; the start bit is confirmed
// at its middle and every following bit is sampled one bit period later, so
// all samples land mid-bit. Each received byte is delivered with a one-cycle
// o_RX_DV strobe and held on o_RX_Byte until the next byte completes.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per UART bit (clk_freq / baud), default 217
//
// Ports:
//   i_Clock   system clock, rising edge
//   i_Rst_n   asynchronous active-low reset
//   rx_if     uart_rx_if.slave: i_RX_Serial in, o_RX_DV / o_RX_Byte out
//             (plus o_RX_Frame_Err when UART_RX_FRAMING_ERR_EN is defined)
//
// Build option:
//   UART_RX_FRAMING_ERR_EN  when defined, a low stop bit suppresses o_RX_DV,
//                           keeps o_RX_Byte and pulses o_RX_Frame_Err instead.
//                           When undefined the stop bit value is ignored.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input logic      i_Clock,
  input logic      i_Rst_n,
  uart_rx_if.slave rx_if
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CNT_W-1:0] MID_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_CLEANUP = 3'd4;

  logic             rx_meta;
  logic             rx_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;
  logic             rx_dv;
  logic [7:0]       rx_byte;
`ifdef UART_RX_FRAMING_ERR_EN
  logic             frame_err;
`endif

  // Two-flop synchroniser; preset to the idle level so reset never looks
  // like a start bit.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_if.i_RX_Serial;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM. The clock counter is cleared on every state change, so each
  // state measures time from its own entry: START waits half a bit, DATA and
  // STOP wait a full bit, which keeps all samples at mid-bit.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= S_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      rx_shift  <= '0;
      rx_dv     <= 1'b0;
      rx_byte   <= '0;
`ifdef UART_RX_FRAMING_ERR_EN
      frame_err <= 1'b0;
`endif
    end else begin
      rx_dv     <= 1'b0;
`ifdef UART_RX_FRAMING_ERR_EN
      frame_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_s) begin
            state <= S_START;
          end
        end

        S_START: begin
          if (clk_cnt == MID_CNT) begin
            clk_cnt <= '0;
            // Line back high at mid start bit: a glitch, not a frame.
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (clk_cnt == BIT_END) begin
            clk_cnt           <= '0;
            rx_shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (clk_cnt == BIT_END) begin
            clk_cnt <= '0;
            state   <= S_CLEANUP;
`ifdef UART_RX_FRAMING_ERR_EN
            if (rx_s) begin
              rx_byte <= rx_shift;
              rx_dv   <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
`else
            rx_byte <= rx_shift;
            rx_dv   <= 1'b1;
`endif
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        S_CLEANUP: begin
          clk_cnt <= '0;
          state   <= S_IDLE;
        end

        default: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_if.o_RX_DV   = rx_dv;
  assign rx_if.o_RX_Byte = rx_byte;
`ifdef UART_RX_FRAMING_ERR_EN
  assign rx_if.o_RX_Frame_Err = frame_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx - self-checking bench for uart_rx (25 MHz clock, 217 clocks/bit).
// Expected bytes come from what the bench itself puts on the line: a good
// frame yields exactly that byte, a rejected frame yields nothing.
module tb_uart_rx;

  localparam int CPB = 217;

  logic clk = 1'b0;
  logic rst_n;

  always #20 clk = ~clk;

  uart_rx_if rx_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
    .rx_if   (rx_if)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  logic [7:0] got_q[$];
  int         width_q[$];
  int         dv_run      = 0;
  int         byte_glitch = 0;
  logic [7:0] prev_byte   = 8'h00;
  int         ferr_cnt    = 0;
`ifdef UART_RX_FRAMING_ERR_EN
  int         fe_run      = 0;
`endif

  always @(negedge clk) begin
    if (rx_if.o_RX_DV === 1'b1) begin
      if (dv_run == 0) got_q.push_back(rx_if.o_RX_Byte);
      dv_run++;
    end else if (dv_run != 0) begin
      width_q.push_back(dv_run);
      dv_run = 0;
    end
    if (rst_n && rx_if.o_RX_Byte !== prev_byte && rx_if.o_RX_DV !== 1'b1)
      byte_glitch++;
    prev_byte = rx_if.o_RX_Byte;
`ifdef UART_RX_FRAMING_ERR_EN
    if (rx_if.o_RX_Frame_Err === 1'b1) begin
      if (fe_run == 0) ferr_cnt++;
      fe_run++;
    end else if (fe_run != 0) begin
      width_q.push_back(fe_run);
      fe_run = 0;
    end
`endif
  end

  task automatic line_hold(input logic v, input int n);
    rx_if.i_RX_Serial = v;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int bit_clks, input int start_clks,
                            input logic stop_v, input int stop_clks);
    line_hold(1'b0, start_clks);
    for (int i = 0; i < 8; i++) line_hold(d[i], bit_clks);
    line_hold(stop_v, stop_clks);
    rx_if.i_RX_Serial = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    int         bit_clks;
    int         start_clks;
    logic       stop_v;
    int         stop_clks;
    int         exp_dv;
    logic [7:0] exp_byte;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  logic [7:0] exp_q[$];
  logic [7:0] a5;
  int         n0;
  int         f0;

  initial begin
    // data, bit, start, stop value, stop len, DVs, byte after, frame errors
    vecs[0] = '{8'h37, 215, 240, 1'b1, 215, 1, 8'h37, 0};
    vecs[1] = '{8'hA5, 217, 217, 1'b1, 217, 1, 8'hA5, 0};
`ifdef UART_RX_FRAMING_ERR_EN
    vecs[2] = '{8'hC3, 217, 217, 1'b0, 150, 0, 8'hA5, 1};
`else
    vecs[2] = '{8'hC3, 217, 217, 1'b0, 150, 1, 8'hC3, 0};
`endif
    vecs[3] = '{8'h5A, 222, 222, 1'b1, 222, 1, 8'h5A, 0};
    vecs[4] = '{8'h81, 212, 212, 1'b1, 212, 1, 8'h81, 0};
    vecs[5] = '{8'h00, 217, 217, 1'b1, 217, 1, 8'h00, 0};

    rx_if.i_RX_Serial = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_dv", {31'd0, rx_if.o_RX_DV}, 32'd0);
    check("reset_byte", {24'd0, rx_if.o_RX_Byte}, 32'd0);
`ifdef UART_RX_FRAMING_ERR_EN
    check("reset_ferr", {31'd0, rx_if.o_RX_Frame_Err}, 32'd0);
`endif
    repeat (4) @(posedge clk);
    rst_n = 1'b1;
    line_hold(1'b1, 20);

    // Table of single frames with timing variations.
    for (int v = 0; v < 6; v++) begin
      n0 = got_q.size();
      f0 = ferr_cnt;
      send_frame(vecs[v].data, vecs[v].bit_clks, vecs[v].start_clks,
                 vecs[v].stop_v, vecs[v].stop_clks);
      @(negedge clk);
      check($sformatf("vec%0d_hold", v), {24'd0, rx_if.o_RX_Byte}, {24'd0, vecs[v].exp_byte});
      line_hold(1'b1, 300);
      check($sformatf("vec%0d_dv_count", v), got_q.size() - n0, vecs[v].exp_dv);
      if (vecs[v].exp_dv == 1 && got_q.size() > n0)
        check($sformatf("vec%0d_byte", v), {24'd0, got_q[n0]}, {24'd0, vecs[v].exp_byte});
      check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
    end

    // Back-to-back frames, no idle gap.
    n0 = got_q.size();
    send_frame(8'h00, CPB, CPB, 1'b1, CPB);
    send_frame(8'hFF, CPB, CPB, 1'b1, CPB);
    line_hold(1'b1, 300);
    check("b2b_count", got_q.size() - n0, 2);
    if (got_q.size() >= n0 + 2) begin
      check("b2b_first", {24'd0, got_q[n0]}, 32'h00);
      check("b2b_second", {24'd0, got_q[n0+1]}, 32'hFF);
    end
    check("b2b_held", {24'd0, rx_if.o_RX_Byte}, 32'hFF);

    // 50-clock glitch on idle line.
    n0 = got_q.size();
    line_hold(1'b0, 50);
    line_hold(1'b1, 300);
    check("glitch_no_dv", got_q.size() - n0, 0);
    check("glitch_byte", {24'd0, rx_if.o_RX_Byte}, 32'hFF);

    // Reset during bit 4 of 0xA5, then a clean 0x5A.
    a5 = 8'hA5;
    n0 = got_q.size();
    line_hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) line_hold(a5[i], CPB);
    line_hold(a5[4], 100);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_dv", {31'd0, rx_if.o_RX_DV}, 32'd0);
    check("midrst_byte", {24'd0, rx_if.o_RX_Byte}, 32'd0);
    line_hold(1'b1, 10);
    rst_n = 1'b1;
    line_hold(1'b1, 50);
    check("midrst_no_dv", got_q.size() - n0, 0);
    send_frame(8'h5A, CPB, CPB, 1'b1, CPB);
    line_hold(1'b1, 300);
    check("after_rst_count", got_q.size() - n0, 1);
    if (got_q.size() > n0)
      check("after_rst_byte", {24'd0, got_q[n0]}, 32'h5A);

    // Random bytes, bit lengths within tolerance, random idle gaps.
    n0 = got_q.size();
    for (int r = 0; r < 12; r++) begin
      logic [7:0] d;
      int         bc;
      d  = 8'($urandom);
      bc = int'($urandom_range(213, 221));
      send_frame(d, bc, bc, 1'b1, bc);
      exp_q.push_back(d);
      line_hold(1'b1, int'($urandom_range(0, 40)));
    end
    line_hold(1'b1, 300);
    check("rand_count", got_q.size() - n0, exp_q.size());
    for (int r = 0; r < exp_q.size(); r++) begin
      if (n0 + r < got_q.size())
        check($sformatf("rand%0d_byte", r), {24'd0, got_q[n0+r]}, {24'd0, exp_q[r]});
    end

    // Every strobe is exactly one clock wide; byte only moves with DV.
    foreach (width_q[i])
      check($sformatf("pulse%0d_width", i), width_q[i], 1);
    check("byte_only_at_dv", byte_glitch, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
